// File: rtl/interrupt_dispatcher_pkg.sv
// Shared definitions for the interrupt dispatcher: source indices, vectors,
// register addresses and FSM state encodings.
package interrupt_dispatcher_pkg;

  localparam int INT_VBLANK = 0;
  localparam int INT_STAT   = 1;
  localparam int INT_TIMER  = 2;
  localparam int INT_SERIAL = 3;
  localparam int INT_JOYPAD = 4;

  localparam logic [15:0] BASE_VEC = 16'h0040;

  // Address decode lives in the bus fabric; these are kept here for reference.
  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  typedef struct packed {
    state_t state;
    logic   ime;
  } dbg_t;

endpackage

// File: rtl/interrupt_dispatcher_lowest_set_bit.sv
// One-hot isolation of the least significant set bit of a vector.
module LowestSetBit #(
  parameter int SIZE = 5
) (
  input  logic [SIZE-1:0] i_Data,
  output logic [SIZE-1:0] o_Data
);

  // Two's complement trick: d & -d keeps only the lowest set bit.
  assign o_Data = i_Data & (~i_Data + SIZE'(1));

endmodule

// File: rtl/interrupt_dispatcher.sv
// Game Boy IF/IE/IME interrupt controller presenting the highest-priority
// pending interrupt to the CPU through a request/acknowledge handshake.
module interrupt_dispatcher
  import interrupt_dispatcher_pkg::*;
#(
  parameter int          NUM_INT  = 5,
  parameter logic [15:0] BASE_VEC = interrupt_dispatcher_pkg::BASE_VEC
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic [NUM_INT-1:0] i_IntRequest,
  input  logic               i_WrIF,
  input  logic               i_WrIE,
  input  logic [7:0]         i_WrData,
  output logic [7:0]         o_IF,
  output logic [7:0]         o_IE,
  input  logic               i_SetIME,
  input  logic               i_ClrIME,
  output logic               o_IntReq,
  output logic [15:0]        o_IntVector,
  input  logic               i_IntAck,
  output logic               o_Wake,
  output dbg_t               o_Dbg
);

  // Handshake: o_IntReq/o_IntVector hold steady while in REQ; i_IntAck is
  // only honoured in REQ and completes the transfer at that clock edge.

  localparam int IDX_W = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;

  logic [NUM_INT-1:0] if_q, if_next, pending, lowest, sel_q;
  logic [7:0]         ie_q;
  logic               ime_q, ime_next, ack_ok;
  logic [IDX_W-1:0]   idx;
  logic [15:0]        vec_q, vec_next;
  logic               req_q;
  state_t             state_q;

  assign pending = if_q & ie_q[NUM_INT-1:0];

  LowestSetBit #(.SIZE(NUM_INT)) u_lowest (
    .i_Data (pending),
    .o_Data (lowest)
  );

  always_comb begin
    idx = '0;
    for (int k = 0; k < NUM_INT; k++) begin
      if (lowest[k]) idx = IDX_W'(k);
    end
  end

  assign vec_next = BASE_VEC + ({{(16-IDX_W){1'b0}}, idx} << 3);
  assign ack_ok   = (state_q == REQ) && i_IntAck;

  // Write, then ack clear, then request OR-in: a peripheral pulse always wins.
  always_comb begin
    if_next = if_q;
    if (i_WrIF) if_next = i_WrData[NUM_INT-1:0];
    if (ack_ok) if_next = if_next & ~sel_q;
    if_next = if_next | i_IntRequest;
  end

  always_comb begin
    ime_next = ime_q;
    if (i_ClrIME || ack_ok) ime_next = 1'b0;
    else if (i_SetIME)      ime_next = 1'b1;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      if_q    <= '0;
      ie_q    <= '0;
      ime_q   <= 1'b0;
      sel_q   <= '0;
      vec_q   <= '0;
      req_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      if_q  <= if_next;
      ime_q <= ime_next;
      if (i_WrIE) ie_q <= i_WrData;
      case (state_q)
        IDLE: begin
          if (ime_q && (|pending)) begin
            sel_q   <= lowest;
            vec_q   <= vec_next;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (ack_ok || !ime_q || !(|(sel_q & pending))) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    o_IF                = 8'hFF;
    o_IF[NUM_INT-1:0]   = if_q;
  end

  assign o_IE        = ie_q;
  assign o_IntReq    = req_q;
  assign o_IntVector = vec_q;
  assign o_Wake      = |pending;
  assign o_Dbg       = '{state: state_q, ime: ime_q};

endmodule

// File: tb/tb_interrupt_dispatcher.sv
// Directed self-checking bench for interrupt_dispatcher.
module tb_interrupt_dispatcher;
  import interrupt_dispatcher_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  int_req = '0;
  logic        wr_if = 1'b0, wr_ie = 1'b0;
  logic [7:0]  wr_data = '0;
  logic [7:0]  rd_if, rd_ie;
  logic        set_ime = 1'b0, clr_ime = 1'b0;
  logic        irq;
  logic [15:0] vec;
  logic        ack = 1'b0;
  logic        wake;
  dbg_t        dbg;

  int errors = 0;
  int checks = 0;

  interrupt_dispatcher #(.NUM_INT(5), .BASE_VEC(16'h0040)) dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_IntRequest (int_req),
    .i_WrIF       (wr_if),
    .i_WrIE       (wr_ie),
    .i_WrData     (wr_data),
    .o_IF         (rd_if),
    .o_IE         (rd_ie),
    .i_SetIME     (set_ime),
    .i_ClrIME     (clr_ime),
    .o_IntReq     (irq),
    .o_IntVector  (vec),
    .i_IntAck     (ack),
    .o_Wake       (wake),
    .o_Dbg        (dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    int_req = '0; wr_if = 0; wr_ie = 0; wr_data = '0;
    set_ime = 0; clr_ime = 0; ack = 0;
  endtask

  task automatic test_reset();
    rst = 1; tick(); rst = 0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (vec !== 16'h0000) begin errors++; $display("FAIL reset_vec got=%h exp=0000", vec); end
    checks++; if (rd_if !== 8'hE0) begin errors++; $display("FAIL reset_if got=%h exp=e0", rd_if); end
    checks++; if (rd_ie !== 8'h00) begin errors++; $display("FAIL reset_ie got=%h exp=00", rd_ie); end
    checks++; if (wake !== 1'b0) begin errors++; $display("FAIL reset_wake got=%b exp=0", wake); end
    checks++; if (dbg.ime !== 1'b0) begin errors++; $display("FAIL reset_ime got=%b exp=0", dbg.ime); end
  endtask

  task automatic test_basic_dispatch();
    wr_ie = 1; wr_data = 8'h1F; set_ime = 1; tick(); idle_inputs();
    checks++; if (rd_ie !== 8'h1F) begin errors++; $display("FAIL basic_ie got=%h exp=1f", rd_ie); end
    checks++; if (dbg.ime !== 1'b1) begin errors++; $display("FAIL basic_ime_set got=%b exp=1", dbg.ime); end
    int_req = 5'b00100; tick(); idle_inputs();
    checks++; if (rd_if !== 8'hE4) begin errors++; $display("FAIL basic_if got=%h exp=e4", rd_if); end
    checks++; if (wake !== 1'b1) begin errors++; $display("FAIL basic_wake got=%b exp=1", wake); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_early got=%b exp=0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq got=%b exp=1", irq); end
    checks++; if (vec !== 16'h0050) begin errors++; $display("FAIL basic_vec got=%h exp=0050", vec); end
    ack = 1; tick(); idle_inputs();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_after_ack got=%b exp=0", irq); end
    checks++; if (rd_if !== 8'hE0) begin errors++; $display("FAIL basic_if_after_ack got=%h exp=e0", rd_if); end
    checks++; if (dbg.ime !== 1'b0) begin errors++; $display("FAIL basic_ime_after_ack got=%b exp=0", dbg.ime); end
  endtask

  task automatic test_priority();
    wr_if = 1; wr_data = 8'h16; set_ime = 1; tick(); idle_inputs();
    checks++; if (rd_if !== 8'hF6) begin errors++; $display("FAIL prio_if got=%h exp=f6", rd_if); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL prio_irq got=%b exp=1", irq); end
    checks++; if (vec !== 16'h0048) begin errors++; $display("FAIL prio_vec1 got=%h exp=0048", vec); end
    ack = 1; tick(); idle_inputs();
    checks++; if (rd_if !== 8'hF4) begin errors++; $display("FAIL prio_if_after_ack got=%h exp=f4", rd_if); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL prio_irq_after_ack got=%b exp=0", irq); end
    set_ime = 1; tick(); idle_inputs();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL prio_gap got=%b exp=0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL prio_irq2 got=%b exp=1", irq); end
    checks++; if (vec !== 16'h0050) begin errors++; $display("FAIL prio_vec2 got=%h exp=0050", vec); end
    ack = 1; tick(); idle_inputs();
    checks++; if (rd_if !== 8'hF0) begin errors++; $display("FAIL prio_if_final got=%h exp=f0", rd_if); end
    wr_if = 1; wr_data = 8'h00; tick(); idle_inputs();
  endtask

  task automatic test_no_ime();
    int bad = 0;
    wr_ie = 1; wr_data = 8'h01; tick(); idle_inputs();
    int_req = 5'b00001; tick(); idle_inputs();
    checks++; if (wake !== 1'b1) begin errors++; $display("FAIL noime_wake got=%b exp=1", wake); end
    for (int i = 0; i < 10; i++) begin
      if (irq !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL noime_irq got=%0d cycles high exp=0", bad); end
    wr_if = 1; wr_data = 8'h00; tick(); idle_inputs();
    checks++; if (wake !== 1'b0) begin errors++; $display("FAIL noime_wake_clear got=%b exp=0", wake); end
  endtask

  task automatic test_cancel();
    wr_ie = 1; wr_data = 8'h1F; set_ime = 1; tick(); idle_inputs();
    int_req = 5'b00100; tick(); idle_inputs();
    tick();
    checks++; if (irq !== 1'b1 || vec !== 16'h0050) begin
      errors++; $display("FAIL cancel_req got=%b/%h exp=1/0050", irq, vec);
    end
    wr_if = 1; wr_data = 8'h00; tick(); idle_inputs();
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL cancel_drop got=%b exp=0", irq); end
    checks++; if (dbg.ime !== 1'b1) begin errors++; $display("FAIL cancel_ime got=%b exp=1", dbg.ime); end
    checks++; if (dbg.state !== IDLE) begin errors++; $display("FAIL cancel_state got=%b exp=0", dbg.state); end
  endtask

  task automatic test_same_cycle();
    int_req = 5'b00001; tick(); idle_inputs();
    tick();
    checks++; if (irq !== 1'b1 || vec !== 16'h0040) begin
      errors++; $display("FAIL same_req got=%b/%h exp=1/0040", irq, vec);
    end
    ack = 1; int_req = 5'b00001; tick(); idle_inputs();
    checks++; if (rd_if !== 8'hE1) begin errors++; $display("FAIL same_if got=%h exp=e1", rd_if); end
    checks++; if (dbg.ime !== 1'b0) begin errors++; $display("FAIL same_ime_ack got=%b exp=0", dbg.ime); end
    set_ime = 1; clr_ime = 1; tick(); idle_inputs();
    checks++; if (dbg.ime !== 1'b0) begin errors++; $display("FAIL same_ime_setclr got=%b exp=0", dbg.ime); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL same_irq_noime got=%b exp=0", irq); end
  endtask

  task automatic test_reset_in_req();
    set_ime = 1; tick(); idle_inputs();
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rreq_irq got=%b exp=1", irq); end
    rst = 1; tick(); rst = 0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rreq_irq_after got=%b exp=0", irq); end
    checks++; if (vec !== 16'h0000) begin errors++; $display("FAIL rreq_vec got=%h exp=0000", vec); end
    checks++; if (rd_if !== 8'hE0) begin errors++; $display("FAIL rreq_if got=%h exp=e0", rd_if); end
    checks++; if (rd_ie !== 8'h00) begin errors++; $display("FAIL rreq_ie got=%h exp=00", rd_ie); end
    checks++; if (dbg.ime !== 1'b0) begin errors++; $display("FAIL rreq_ime got=%b exp=0", dbg.ime); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic_dispatch();
    test_priority();
    test_no_ime();
    test_cancel();
    test_same_cycle();
    test_reset_in_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
